// File: rtl/pcie_phy_tx_striper.sv
// Transmit framer/striper: buffers DLL bytes, checks packet framing, wraps each
// packet in STP/END, pads with IDL, inserts periodic SKP ordered sets and stripes
// the resulting symbol stream across LANES lanes, one lane per clock.
module pcie_phy_tx_striper #(
   parameter int         LANES        = 4,
   parameter int         FIFO_DEPTH   = 16,
   parameter int         SKP_INTERVAL = 1180,
   parameter int         SKP_LEN      = 3,
   parameter logic [7:0] K_STP        = 8'hFB,
   parameter logic [7:0] K_END        = 8'hFD,
   parameter logic [7:0] K_COM        = 8'hBC,
   parameter logic [7:0] K_SKP        = 8'h1C,
   parameter logic [7:0] K_IDL        = 8'h7C
) (
   input  logic                 clk,
   input  logic                 reset_l,
   input  logic [7:0]           d,
   input  logic [1:0]           control,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 err_clr,
   output logic [8*LANES-1:0]   data_out,
   output logic [LANES-1:0]     control_out,
   output logic                 out_valid,
   output logic                 error_dll
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int SW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
   localparam int GW = (SKP_LEN > 1) ? $clog2(SKP_LEN + 1) : 1;

   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
   localparam logic [SW-1:0] SKP_WRAP  = SW'(SKP_INTERVAL - 1);
   localparam logic [GW-1:0] SKP_LAST  = GW'(SKP_LEN - 1);
   localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic {
      OUT_PKT,
      IN_PKT
   } chk_state_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_END,
      ST_SKP_COM,
      ST_SKP_SYM
   } frm_state_t;

   // byte FIFO: each entry carries the byte plus a "last byte of packet" flag
   logic [8:0]    fifo_mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   level;
   logic          full;
   logic [8:0]    rd_entry;

   // input checker
   chk_state_t    chk_state;
   chk_state_t    chk_next;
   logic          accept;
   logic          push;
   logic          push_last;
   logic          pkt_inc;
   logic          proto_err;
   logic          overflow;
   logic [AW:0]   part_cnt;
   logic [AW:0]   pkt_cnt;
   logic          rdy_q;

   // framer
   frm_state_t    frm_state;
   frm_state_t    frm_next;
   logic [LW-1:0] lane_ptr;
   logic          emit;
   logic [7:0]    sym;
   logic          sym_k;
   logic          pop;
   logic          pkt_dec;
   logic          skp_out;
   logic [7:0]    skp_byte;
   logic          skp_take;
   logic [SW-1:0] skp_cnt;
   logic          skp_pending;
   logic [GW-1:0] skp_grp;
   logic [8*LANES-1:0] grp_data;
   logic [LANES-1:0]   grp_k;
   logic [8*LANES-1:0] grp_data_next;
   logic [LANES-1:0]   grp_k_next;

   assign level    = wr_ptr - rd_ptr;
   assign full     = (level == DEPTH);
   assign rd_entry = fifo_mem[rd_ptr[AW-1:0]];
   assign in_ready = rdy_q && !full;
   assign accept   = in_valid && in_ready;
   // a FIFO filled entirely by one still-open packet can never drain
   assign overflow = full && (pkt_cnt == '0) && (chk_state == IN_PKT);

   // decode each accepted byte against the packet framing rules
   always_comb begin
      chk_next  = chk_state;
      push      = 1'b0;
      push_last = 1'b0;
      pkt_inc   = 1'b0;
      proto_err = 1'b0;
      if (accept) begin
         if (chk_state == OUT_PKT) begin
            case (control)
               2'b01: begin
                  push     = 1'b1;
                  chk_next = IN_PKT;
               end
               2'b11: begin
                  push      = 1'b1;
                  push_last = 1'b1;
                  pkt_inc   = 1'b1;
               end
               default: proto_err = 1'b1;
            endcase
         end else begin
            case (control)
               2'b00: push = 1'b1;
               2'b10: begin
                  push      = 1'b1;
                  push_last = 1'b1;
                  pkt_inc   = 1'b1;
                  chk_next  = OUT_PKT;
               end
               default: begin
                  proto_err = 1'b1;
                  chk_next  = OUT_PKT;
               end
            endcase
         end
      end
      if (overflow) begin
         chk_next = OUT_PKT;
      end
   end

   // FIFO storage write; contents need no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[AW-1:0]] <= {push_last, d};
      end
   end

   // checker state, FIFO pointers, open-packet length, packet count and error flag
   always_ff @(posedge clk) begin
      if (!reset_l) begin
         chk_state <= OUT_PKT;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         part_cnt  <= '0;
         pkt_cnt   <= '0;
         error_dll <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         chk_state <= chk_next;
         rdy_q     <= 1'b1;
         if (overflow) begin
            wr_ptr   <= rd_ptr;
            part_cnt <= '0;
         end else if (proto_err) begin
            wr_ptr   <= wr_ptr - part_cnt;
            part_cnt <= '0;
         end else if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            part_cnt <= push_last ? '0 : part_cnt + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({pkt_inc, pkt_dec})
            2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
            2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
            default: pkt_cnt <= pkt_cnt;
         endcase
         if (overflow || proto_err) begin
            error_dll <= 1'b1;
         end else if (err_clr) begin
            error_dll <= 1'b0;
         end
      end
   end

   // framer next-state: choose the symbol for the current lane or a whole SKP group
   always_comb begin
      frm_next = frm_state;
      emit     = 1'b0;
      sym      = K_IDL;
      sym_k    = 1'b1;
      pop      = 1'b0;
      pkt_dec  = 1'b0;
      skp_out  = 1'b0;
      skp_byte = K_SKP;
      skp_take = 1'b0;
      case (frm_state)
         ST_IDLE: begin
            if (skp_pending && (lane_ptr == '0)) begin
               skp_take = 1'b1;
               frm_next = ST_SKP_COM;
            end else if (pkt_cnt != '0) begin
               emit     = 1'b1;
               sym      = K_STP;
               frm_next = ST_DATA;
            end else begin
               emit = 1'b1;
            end
         end
         ST_DATA: begin
            pop   = 1'b1;
            emit  = 1'b1;
            sym   = rd_entry[7:0];
            sym_k = 1'b0;
            if (rd_entry[8]) begin
               frm_next = ST_END;
            end
         end
         ST_END: begin
            emit     = 1'b1;
            sym      = K_END;
            pkt_dec  = 1'b1;
            frm_next = ST_IDLE;
         end
         ST_SKP_COM: begin
            skp_out  = 1'b1;
            skp_byte = K_COM;
            frm_next = ST_SKP_SYM;
         end
         ST_SKP_SYM: begin
            skp_out = 1'b1;
            if (skp_grp == SKP_LAST) begin
               frm_next = ST_IDLE;
            end
         end
         default: frm_next = ST_IDLE;
      endcase
   end

   // merge the current symbol into the partially built lane group
   always_comb begin
      grp_data_next = grp_data;
      grp_k_next    = grp_k;
      if (emit) begin
         grp_data_next[8*lane_ptr +: 8] = sym;
         grp_k_next[lane_ptr]           = sym_k;
      end
   end

   // framer state, lane pointer, SKP scheduling and registered output group
   always_ff @(posedge clk) begin
      if (!reset_l) begin
         frm_state   <= ST_IDLE;
         lane_ptr    <= '0;
         skp_cnt     <= '0;
         skp_pending <= 1'b0;
         skp_grp     <= '0;
         grp_data    <= '0;
         grp_k       <= '0;
         data_out    <= '0;
         control_out <= '0;
         out_valid   <= 1'b0;
      end else begin
         frm_state <= frm_next;
         if (skp_take) begin
            skp_pending <= 1'b0;
         end
         if (skp_cnt == SKP_WRAP) begin
            skp_cnt     <= '0;
            skp_pending <= 1'b1;
         end else begin
            skp_cnt <= skp_cnt + 1'b1;
         end
         if (frm_state == ST_SKP_COM) begin
            skp_grp <= '0;
         end else if (frm_state == ST_SKP_SYM) begin
            skp_grp <= skp_grp + 1'b1;
         end
         out_valid <= 1'b0;
         if (emit) begin
            grp_data <= grp_data_next;
            grp_k    <= grp_k_next;
            if (lane_ptr == LAST_LANE) begin
               lane_ptr    <= '0;
               data_out    <= grp_data_next;
               control_out <= grp_k_next;
               out_valid   <= 1'b1;
            end else begin
               lane_ptr <= lane_ptr + 1'b1;
            end
         end else if (skp_out) begin
            data_out    <= {LANES{skp_byte}};
            control_out <= '1;
            out_valid   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pcie_phy_tx_striper.sv
// Bench for pcie_phy_tx_striper: directed framing/SKP/error/reset scenarios plus
// random packet traffic, with a symbol-stream parser checking every output group.
module tb_pcie_phy_tx_striper;

   localparam int LANES        = 4;
   localparam int FIFO_DEPTH   = 16;
   localparam int SKP_INTERVAL = 64;
   localparam int SKP_LEN      = 3;

   logic                 clk = 1'b0;
   logic                 reset_l = 1'b0;
   logic [7:0]           d = '0;
   logic [1:0]           control = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic                 err_clr = 1'b0;
   logic [8*LANES-1:0]   data_out;
   logic [LANES-1:0]     control_out;
   logic                 out_valid;
   logic                 error_dll;

   int checkCount = 0;
   int errCount   = 0;

   // expected packets (lengths and concatenated bytes) and parser state
   int         expLen[$];
   logic [7:0] expBytes[$];
   bit         inPkt = 0;
   int         curLen = 0;
   int         curIdx = 0;
   int         skpLeft = 0;
   int         skpSets = 0;
   int         pktsSeen = 0;
   logic [7:0] monSym;
   logic       monK;

   pcie_phy_tx_striper #(
      .LANES(LANES), .FIFO_DEPTH(FIFO_DEPTH),
      .SKP_INTERVAL(SKP_INTERVAL), .SKP_LEN(SKP_LEN)
   ) dut (
      .clk(clk), .reset_l(reset_l), .d(d), .control(control),
      .in_valid(in_valid), .in_ready(in_ready), .err_clr(err_clr),
      .data_out(data_out), .control_out(control_out),
      .out_valid(out_valid), .error_dll(error_dll)
   );

   // free-running clock
   always #5 clk = ~clk;

   // count one comparison and report it when observed differs from expected
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // offer one byte at a negedge and hold it until the DUT accepts it
   task automatic applyStimulus(input logic [1:0] ctl, input logic [7:0] b);
      int n;
      @(negedge clk);
      d        = b;
      control  = ctl;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checkOutput("in_ready_timeout", in_ready, 1);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // send a well-formed packet of random bytes and record it as expected output
   task automatic sendPacket(input int len, input int gapMax);
      logic [7:0] b;
      logic [1:0] ctl;
      expLen.push_back(len);
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom_range(0, 255));
         expBytes.push_back(b);
         if (len == 1)            ctl = 2'b11;
         else if (i == 0)         ctl = 2'b01;
         else if (i == len - 1)   ctl = 2'b10;
         else                     ctl = 2'b00;
         applyStimulus(ctl, b);
         repeat ($urandom_range(0, gapMax)) @(negedge clk);
      end
   endtask

   // wait (bounded) until every expected packet has come out completely
   task automatic waitDrain();
      int n;
      n = 0;
      while ((expLen.size() != 0 || inPkt) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_pkts_left", expLen.size(), 0);
      checkOutput("drain_in_pkt", inPkt, 0);
   endtask

   // pulse err_clr for one cycle and confirm the flag drops
   task automatic clearError();
      @(negedge clk);
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      checkOutput("err_cleared", error_dll, 0);
   endtask

   // stream parser: IDL/STP outside packets, data then END inside, SKP sets only between packets
   always @(negedge clk) begin
      if (!reset_l) begin
         expLen.delete();
         expBytes.delete();
         inPkt   = 0;
         skpLeft = 0;
      end else if (out_valid) begin
         if (skpLeft > 0) begin
            checkOutput("skp_group", {control_out, data_out}, {4'hF, 32'h1C1C1C1C});
            skpLeft--;
         end else if (data_out == {LANES{8'hBC}} && control_out == '1) begin
            checkOutput("com_outside_pkt", inPkt, 0);
            skpLeft = SKP_LEN;
            skpSets++;
         end else begin
            for (int i = 0; i < LANES; i++) begin
               monSym = data_out[8*i +: 8];
               monK   = control_out[i];
               if (!inPkt) begin
                  if (monK && monSym == 8'hFB) begin
                     checkOutput("stp_has_pkt", expLen.size() > 0, 1);
                     if (expLen.size() > 0) begin
                        curLen = expLen.pop_front();
                        curIdx = 0;
                        inPkt  = 1;
                     end
                  end else begin
                     checkOutput("idle_symbol", {monK, monSym}, {1'b1, 8'h7C});
                  end
               end else if (!monK) begin
                  checkOutput("data_within_len", curIdx < curLen, 1);
                  if (curIdx < curLen && expBytes.size() > 0) begin
                     checkOutput("data_byte", monSym, expBytes.pop_front());
                  end
                  curIdx++;
               end else begin
                  checkOutput("end_symbol", {monK, monSym}, {1'b1, 8'hFD});
                  checkOutput("pkt_length", curIdx, curLen);
                  inPkt = 0;
                  pktsSeen++;
               end
            end
         end
      end
   end

   int  gap;
   int  n;
   int  base;
   int  sent;
   bit  found;

   initial begin
      // reset held for 5 cycles: outputs quiet, not ready
      repeat (5) @(negedge clk);
      checkOutput("rst_data_out", data_out, 0);
      checkOutput("rst_control_out", control_out, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_error", error_dll, 0);
      reset_l = 1'b1;

      // idle stream: IDL groups every 4 cycles
      for (int g = 0; g < 3; g++) begin
         gap = 0;
         found = 0;
         while (!found && gap < 10) begin
            @(negedge clk);
            gap++;
            found = out_valid;
         end
         checkOutput("idle_group", {control_out, data_out}, {4'hF, 32'h7C7C7C7C});
         if (g > 0) checkOutput("idle_period", gap, 4);
      end
      checkOutput("ready_after_reset", in_ready, 1);

      // 3-byte packet timed so that STP lands on lane 0
      expLen.push_back(3);
      expBytes.push_back(8'hA0);
      expBytes.push_back(8'hA1);
      expBytes.push_back(8'hA2);
      applyStimulus(2'b01, 8'hA0);
      applyStimulus(2'b00, 8'hA1);
      applyStimulus(2'b10, 8'hA2);
      found = 0;
      n = 0;
      while (!found && n < 30) begin
         @(negedge clk);
         n++;
         found = out_valid && control_out[0] && data_out[7:0] == 8'hFB;
      end
      checkOutput("stp_group_found", found, 1);
      checkOutput("stp_group", {control_out, data_out}, {4'b0001, 32'hA2A1A0FB});
      found = 0;
      n = 0;
      while (!found && n < 10) begin
         @(negedge clk);
         n++;
         found = out_valid;
      end
      checkOutput("end_group", {control_out, data_out}, {4'hF, 32'h7C7C7CFD});
      waitDrain();

      // single-byte packet, then a maximum-length packet filling the FIFO
      base = pktsSeen;
      sendPacket(1, 0);
      waitDrain();
      sendPacket(FIFO_DEPTH, 0);
      @(negedge clk);
      checkOutput("full_not_ready", in_ready, 0);
      checkOutput("full_no_error", error_dll, 0);
      waitDrain();
      checkOutput("pkts_directed", pktsSeen - base, 2);

      // stray middle byte outside a packet: dropped and flagged
      applyStimulus(2'b00, 8'h99);
      checkOutput("stray_error", error_dll, 1);
      clearError();
      // restart inside a packet: partial bytes flushed
      applyStimulus(2'b01, 8'h11);
      applyStimulus(2'b00, 8'h22);
      applyStimulus(2'b01, 8'h33);
      checkOutput("restart_error", error_dll, 1);
      clearError();
      // new error while clearing: error stays set
      err_clr = 1'b1;
      applyStimulus(2'b10, 8'h44);
      err_clr = 1'b0;
      checkOutput("error_beats_clear", error_dll, 1);
      clearError();
      // open packet filling the FIFO with no complete packet: flushed and flagged
      applyStimulus(2'b01, 8'h50);
      for (int i = 1; i < FIFO_DEPTH; i++) applyStimulus(2'b00, 8'(8'h50 + i));
      @(negedge clk);
      @(negedge clk);
      checkOutput("overflow_error", error_dll, 1);
      checkOutput("overflow_ready", in_ready, 1);
      clearError();
      base = pktsSeen;
      sendPacket(5, 1);
      waitDrain();
      checkOutput("pkts_after_errors", pktsSeen - base, 1);

      // random traffic across many SKP intervals
      base = pktsSeen;
      n = skpSets;
      sent = 0;
      for (int p = 0; p < 40; p++) begin
         sendPacket($urandom_range(1, FIFO_DEPTH), $urandom_range(0, 2));
         sent++;
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      waitDrain();
      checkOutput("pkts_random", pktsSeen - base, sent);
      checkOutput("skp_during_traffic", skpSets > n, 1);
      checkOutput("random_no_error", error_dll, 0);

      // reset mid-packet: outputs return to reset values, stream restarts with IDL
      sendPacket(10, 0);
      repeat (3) @(negedge clk);
      reset_l = 1'b0;
      @(negedge clk);
      checkOutput("midrst_data_out", data_out, 0);
      checkOutput("midrst_control_out", control_out, 0);
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_in_ready", in_ready, 0);
      @(negedge clk);
      reset_l = 1'b1;
      n = skpSets;
      base = pktsSeen;
      found = 0;
      gap = 0;
      while (!found && gap < 10) begin
         @(negedge clk);
         gap++;
         found = out_valid;
      end
      checkOutput("restart_idle_group", {control_out, data_out}, {4'hF, 32'h7C7C7C7C});
      // idle after reset: exactly one SKP ordered set within the first 100 cycles
      repeat (100 - gap) @(negedge clk);
      checkOutput("skp_sets_idle", skpSets - n, 1);
      checkOutput("no_pkt_after_reset", pktsSeen - base, 0);
      checkOutput("skp_done", skpLeft, 0);
      checkOutput("ready_after_midrst", in_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, errCount);
      $finish;
   end

endmodule
